instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit that generates sequential program-counter addresses, requests 32-bit instruction words from instruction memory, buffers them, and presents them one at a time on `in_bits` to the control unit (`CU`). It is the producer end of the decoder's instruction interface. It also accepts PC redirects from branch/jump resolution and discards stale in-flight fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `FIFO_DEPTH`, default 2: instruction buffer entries; also the maximum number of outstanding memory requests. Legal values are ≥2.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_req_addr`  out  32  word-aligned fetch address.
- `imem_rsp_valid`  in  1  response valid. Responses are in order, at least 1 cycle after acceptance, and cannot be backpressured.
- `imem_rsp_data`  in  32  instruction word.
- `in_bits`  out  32  instruction word to the decoder.
- `inst_pc`  out  32  PC of `in_bits`.
- `inst_valid`  out  1  `in_bits`/`inst_pc` valid.
- `inst_ready`  in  1  decoder consumes the instruction.
- `redirect_valid`  in  1  single-cycle PC redirect.
- `redirect_pc`  in  32  redirect target.
- `fetch_misalign`  out  1  sticky misaligned-target flag (see Configuration).

## Operation
- `fetch_pc` reset value is `RESET_PC`. It advances by 4 on each accepted request (`imem_req_valid & imem_req_ready`) and wraps modulo 2^32 (0xFFFF_FFFC → 0).
- Each accepted request pushes its address into a PC tag queue, so every response is paired with its PC.
- Credit rule: `imem_req_valid` = 1 when occupancy + outstanding − pop < `FIFO_DEPTH`, `redirect_valid` = 0, and the block is not halted. pop = `inst_valid & inst_ready`.
- A response with no pending drop is written to the FIFO together with its tagged PC.
- A consume (`inst_valid & inst_ready`) pops the FIFO head.
- Redirect, in the same edge:
  - `fetch_pc` ← `redirect_pc`.
  - FIFO is cleared.
  - `drop_cnt` ← outstanding requests not yet responded. The next `drop_cnt` responses are discarded, and `drop_cnt` decrements on each one.
  - A response arriving in the redirect cycle is discarded and not counted.
  - A consume in the redirect cycle completes normally (the decoder keeps that instruction).
- Push and pop in the same cycle: occupancy is unchanged. A push into a full FIFO cannot occur by construction; the bench asserts this.
- States:
  - `RUN`: normal operation.
  - `HALT`: macro only. No requests issue, `inst_valid` = 0, and the state is left only by reset.
- Reset while requests are outstanding: all counters and the FIFO clear. Responses returned after reset is released are treated as stale only if `drop_cnt` is nonzero; reset zeroes it. The memory must therefore be reset together with this block.

## Timing
- Reset values: `imem_req_valid` 0 while `rst` is asserted, `imem_req_addr` = `RESET_PC`, `in_bits` 0, `inst_pc` 0, `inst_valid` 0, `fetch_misalign` 0.
- First request is issued in the first cycle after `rst` deasserts.
- Response latency: a response accepted at edge N gives `inst_valid` = 1 from cycle N+1. The FIFO is registered and has no bypass.
- Throughput: sustains 1 instruction/cycle with 1-cycle memory latency, `FIFO_DEPTH` = 2, and `inst_ready` held at 1.
- Redirect-to-first-request latency: the request for `redirect_pc` is issued the cycle after the redirect.
- `imem_req_addr` and `imem_req_valid` are stable while stalled (`imem_req_ready` = 0).

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0]` ≠ 0 sets `fetch_misalign` and moves the block to `HALT`.
  - The FIFO is flushed as for any redirect, and no request is issued to the misaligned address.
- `FETCH_MISALIGN_CHECK_EN` undefined:
  - `fetch_misalign` is tied to 0.
  - `redirect_pc[1:0]` is forced to 0 (silently aligned).
  - There is no `HALT` state.

## Structure
- Package `fetch_pkg` holds:
  - `DEFAULT_RESET_PC`.
  - `PC_STEP` = 4.
  - State enum {`RUN`, `HALT`}.
  - `inst_entry_t` struct {pc[31:0], insn[31:0]}.
- Sub-module `fetch_fifo`: a synchronous `FIFO_DEPTH`-entry queue of `inst_entry_t` with push, pop, flush, count, full and empty. It is used for the instruction buffer. The PC tag queue is a second instance.

## Test plan
- Reset release with 1-cycle memory and `inst_ready` = 1 → requests to 0x0, 0x4, 0x8 on consecutive cycles; `in_bits` = mem[0] with `inst_pc` 0x0 two cycles after reset release, then one instruction per cycle.
- `inst_ready` = 0 for 5 cycles → `imem_req_valid` drops after 2 outstanding-or-buffered entries; no instruction lost; order preserved when `inst_ready` returns.
- `redirect_valid` with `redirect_pc` = 0x100 while 2 requests are outstanding → both late responses dropped; next `inst_valid` shows `inst_pc` 0x100.
- Redirect in the same cycle as a consume and a response → the consumed instruction is retired; the response is dropped; `drop_cnt` is correct.
- `fetch_pc` at 0xFFFF_FFFC → next request address is 0x0000_0000.
- Macro defined, redirect to 0x102 → `fetch_misalign` = 1; no further requests; `inst_valid` = 0 until `rst`.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } inst_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous circular queue of inst_entry_t with flush; head is a registered
// storage read, so a push becomes visible the cycle after it is written.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  inst_entry_t   din,
    input  logic          pop,
    input  logic          flush,
    output inst_entry_t   head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    inst_entry_t   mem_q [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem_q[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr] <= din;
                wr_ptr        <= ptr_inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Sequential instruction fetch with credit-limited requests, a PC tag queue,
// an instruction buffer and redirect flush. Optional FETCH_MISALIGN_CHECK_EN.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] in_bits,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_misalign
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int DW = 16;

    logic [31:0]   fetch_pc;
    logic [DW-1:0] drop_cnt;
    logic [31:0]   target_pc;
    logic          running;
    logic          pop;
    logic          req_fire;
    logic          rsp_live;
    logic [CW:0]   in_use;

    inst_entry_t   ibuf_head, tag_head;
    logic [CW-1:0] ibuf_count, tag_count;
    logic          ibuf_full, ibuf_empty, tag_full, tag_empty;
    logic          unused_ok;

`ifdef FETCH_MISALIGN_CHECK_EN
    fetch_state_t state;
    logic         misalign_q;

    assign running        = (state == RUN);
    assign target_pc      = redirect_pc;
    assign fetch_misalign = misalign_q;
    assign unused_ok      = ^{tag_head.insn, tag_full, tag_empty, ibuf_full};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            misalign_q <= 1'b0;
        end else if (redirect_valid && redirect_pc[1:0] != 2'b00) begin
            state      <= HALT;
            misalign_q <= 1'b1;
        end
    end
`else
    assign running        = 1'b1;
    assign target_pc      = {redirect_pc[31:2], 2'b00};
    assign fetch_misalign = 1'b0;
    assign unused_ok      = ^{tag_head.insn, tag_full, tag_empty, ibuf_full, redirect_pc[1:0]};
`endif

    assign inst_valid = running & ~ibuf_empty;
    assign in_bits    = ibuf_head.insn;
    assign inst_pc    = ibuf_head.pc;
    assign pop        = inst_valid & inst_ready;

    // Buffered plus in-flight live fetches; stale ones awaiting drop do not consume credit.
    assign in_use         = {1'b0, ibuf_count} + {1'b0, tag_count} - (CW+1)'(pop);
    assign imem_req_valid = ~rst & running & ~redirect_valid & (in_use < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign rsp_live       = imem_rsp_valid & ~redirect_valid & running & (drop_cnt == '0);

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_ibuf (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_live),
        .din   ('{pc: tag_head.pc, insn: imem_rsp_data}),
        .pop   (pop),
        .flush (redirect_valid),
        .head  (ibuf_head),
        .count (ibuf_count),
        .full  (ibuf_full),
        .empty (ibuf_empty)
    );

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_tags (
        .clk   (clk),
        .rst   (rst),
        .push  (req_fire),
        .din   ('{pc: fetch_pc, insn: 32'h0}),
        .pop   (rsp_live),
        .flush (redirect_valid),
        .head  (tag_head),
        .count (tag_count),
        .full  (tag_full),
        .empty (tag_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= target_pc;
            // Every fetch still in flight becomes stale; a response landing now is already gone.
            drop_cnt <= drop_cnt + DW'(tag_count) - DW'(imem_rsp_valid);
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
            if (imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: queue-based reference model plus directed
// literal checks; memory model returns in-order responses with random latency.
module tb_instr_fetch;

    localparam int          D   = 2;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] in_bits, inst_pc;
    logic        inst_valid, inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_misalign;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(D)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .in_bits        (in_bits),
        .inst_pc        (inst_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_misalign (fetch_misalign)
    );

    typedef struct { logic [31:0] addr; int due; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] insn; } ent_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat_min = 1, lat_max = 1;

    pend_t       pend[$];
    ent_t        mbuf[$];
    logic [31:0] mtag[$];
    logic [31:0] m_pc;
    int          m_drop;
    bit          m_halt, m_mis;

    bit          g_ird, g_rrdy, g_redir;
    logic [31:0] g_rpc;

    logic        obs_rv, obs_iv;
    logic [31:0] obs_addr, obs_pc, obs_bits;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic model_clear();
        mbuf.delete(); mtag.delete(); pend.delete();
        m_pc = RPC; m_drop = 0; m_halt = 0; m_mis = 0;
    endtask

    // One clock: drive at negedge, check, update model across the posedge.
    task automatic cycle();
        bit rsp, ev, pop, ereq, acc;
        rsp = (pend.size() > 0) && (pend[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(pend[0].addr) : $urandom;
        inst_ready     = g_ird;
        imem_req_ready = g_rrdy;
        redirect_valid = g_redir;
        redirect_pc    = g_rpc;
        #1;
        ev   = !m_halt && mbuf.size() > 0;
        pop  = ev && g_ird;
        ereq = !m_halt && !g_redir && (mbuf.size() + mtag.size() - int'(pop) < D);
        obs_rv = imem_req_valid; obs_iv = inst_valid;
        obs_addr = imem_req_addr; obs_pc = inst_pc; obs_bits = in_bits;
        chk("req_valid", {31'b0, imem_req_valid}, {31'b0, ereq});
        if (!m_halt) chk("req_addr", imem_req_addr, m_pc);
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, ev});
        if (ev) begin
            chk("inst_pc", inst_pc, mbuf[0].pc);
            chk("in_bits", in_bits, mbuf[0].insn);
        end
        chk("misalign", {31'b0, fetch_misalign}, {31'b0, m_mis});
        acc = ereq && g_rrdy;
        @(posedge clk);
        cyc++;
        if (rsp) pend.delete(0);
        if (acc) pend.push_back('{m_pc, cyc + int'($urandom_range(lat_min, lat_max)) - 1});
        if (!m_halt) begin
            if (g_redir) begin
                mbuf.delete();
                m_drop = m_drop + mtag.size() - int'(rsp);
                mtag.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
                m_pc = g_rpc;
                if (g_rpc[1:0] != 2'b00) begin m_halt = 1; m_mis = 1; end
`else
                m_pc = g_rpc & ~32'h3;
`endif
            end else begin
                if (pop) mbuf.delete(0);
                if (rsp) begin
                    if (m_drop > 0) m_drop--;
                    else if (mtag.size() == 0) begin
                        bad++; $display("FAIL rsp_without_request at cycle %0d", cyc);
                    end else begin
                        mbuf.push_back('{mtag[0], mem_word(mtag[0])});
                        mtag.delete(0);
                    end
                end
                if (acc) begin mtag.push_back(m_pc); m_pc = m_pc + 32'd4; end
                if (mbuf.size() > D) begin
                    bad++; $display("FAIL buffer_overflow: got %0d entries, limit %0d", mbuf.size(), D);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_rsp_valid = 0; inst_ready = 0; imem_req_ready = 0; redirect_valid = 0; redirect_pc = 0;
        model_clear();
        repeat (2) begin @(posedge clk); @(negedge clk); end
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_req_addr", imem_req_addr, RPC);
        chk("rst_in_bits", in_bits, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_misalign", {31'b0, fetch_misalign}, 32'd0);
        rst = 1'b0;
    endtask

    task automatic wait_valid_pc(input string name, input logic [31:0] exp);
        bit found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (obs_iv) begin chk(name, obs_pc, exp); found = 1; end
        end
        if (!found) begin
            total++; bad++;
            $display("FAIL %s: got no inst_valid within 20 cycles, expected pc %h", name, exp);
        end
    endtask

    task automatic steady(input int n);
        g_ird = 1; g_rrdy = 1; g_redir = 0;
        repeat (n) cycle();
    endtask

    initial begin
        rst = 1'b1;
        imem_rsp_valid = 0; imem_rsp_data = 0; inst_ready = 0;
        imem_req_ready = 0; redirect_valid = 0; redirect_pc = 0;
        g_ird = 1; g_rrdy = 1; g_redir = 0; g_rpc = 0;
        @(negedge clk);
        do_reset();

        // Reset release, 1-cycle memory, decoder always ready.
        lat_min = 1; lat_max = 1;
        g_ird = 1; g_rrdy = 1; g_redir = 0;
        cycle(); chk("t1_addr0", obs_addr, 32'h0); chk("t1_rv0", {31'b0, obs_rv}, 32'd1);
        cycle(); chk("t1_addr1", obs_addr, 32'h4);
        cycle(); chk("t1_addr2", obs_addr, 32'h8);
        chk("t1_iv", {31'b0, obs_iv}, 32'd1);
        chk("t1_pc", obs_pc, 32'h0);
        chk("t1_bits", obs_bits, 32'h1357_6420);
        steady(3);

        // Decoder stall: credit runs out, then drain in order.
        g_ird = 0;
        repeat (5) cycle();
        chk("t2_rv_stalled", {31'b0, obs_rv}, 32'd0);
        chk("t2_iv_stalled", {31'b0, obs_iv}, 32'd1);
        steady(6);

        // Redirect with slow memory: in-flight responses must be dropped.
        lat_min = 3; lat_max = 3;
        steady(6);
        g_redir = 1; g_rpc = 32'h100; cycle(); g_redir = 0;
        cycle();
        chk("t3_addr", obs_addr, 32'h100);
        chk("t3_rv", {31'b0, obs_rv}, 32'd1);
        wait_valid_pc("t3_first_pc", 32'h100);
        steady(4);

        // Redirect coinciding with a consume and a response.
        lat_min = 1; lat_max = 1;
        steady(6);
        g_redir = 1; g_rpc = 32'h200; cycle(); g_redir = 0;
        chk("t4_consume_in_redirect", {31'b0, obs_iv}, 32'd1);
        cycle();
        chk("t4_addr", obs_addr, 32'h200);
        wait_valid_pc("t4_first_pc", 32'h200);

        // Address wrap.
        g_redir = 1; g_rpc = 32'hFFFF_FFFC; cycle(); g_redir = 0;
        cycle(); chk("t5_addr_top", obs_addr, 32'hFFFF_FFFC);
        cycle(); chk("t5_addr_wrap", obs_addr, 32'h0);
        wait_valid_pc("t5_pc_top", 32'hFFFF_FFFC);
        cycle(); chk("t5_pc_wrap", obs_pc, 32'h0);
        steady(3);

        // Misaligned redirect target.
        g_redir = 1; g_rpc = 32'h102; cycle(); g_redir = 0;
`ifdef FETCH_MISALIGN_CHECK_EN
        repeat (5) cycle();
        chk("t6_misalign", {31'b0, obs_rv}, 32'd0);
        chk("t6_iv", {31'b0, obs_iv}, 32'd0);
        chk("t6_flag", {31'b0, fetch_misalign}, 32'd1);
        do_reset();
`else
        cycle(); chk("t6_aligned_addr", obs_addr, 32'h100);
        wait_valid_pc("t6_aligned_pc", 32'h100);
`endif

        // Reset while requests are outstanding.
        lat_min = 3; lat_max = 3;
        steady(5);
        @(negedge clk);
        do_reset();
        lat_min = 1; lat_max = 1;
        g_ird = 1; g_rrdy = 1; g_redir = 0;
        wait_valid_pc("t7_pc_after_reset", RPC);

        // Random traffic.
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            g_ird   = ($urandom_range(0, 99) < 70);
            g_rrdy  = ($urandom_range(0, 99) < 70);
            g_redir = ($urandom_range(0, 99) < 3);
`ifdef FETCH_MISALIGN_CHECK_EN
            g_rpc   = $urandom & ~32'h3;
`else
            g_rpc   = $urandom;
`endif
            cycle();
        end
        g_redir = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
